seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/muldiv_core.sv | 94 +++++++++
 rtl/seq_alu.sv | 113 +++++++++++
 tb/tb_seq_alu.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and opcode-class helpers for seq_alu.
package alu_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD    = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB    = 5'd1;
  localparam logic [OP_W-1:0] OP_AND    = 5'd2;
  localparam logic [OP_W-1:0] OP_OR     = 5'd3;
  localparam logic [OP_W-1:0] OP_SLL    = 5'd4;
  localparam logic [OP_W-1:0] OP_SLT    = 5'd5;
  localparam logic [OP_W-1:0] OP_XOR    = 5'd6;
  localparam logic [OP_W-1:0] OP_SRL    = 5'd7;
  localparam logic [OP_W-1:0] OP_SRA    = 5'd8;
  localparam logic [OP_W-1:0] OP_SLTU   = 5'd9;
  localparam logic [OP_W-1:0] OP_MUL    = 5'd10;
  localparam logic [OP_W-1:0] OP_MULH   = 5'd11;
  localparam logic [OP_W-1:0] OP_MULHSU = 5'd12;
  localparam logic [OP_W-1:0] OP_MULHU  = 5'd13;
  localparam logic [OP_W-1:0] OP_DIV    = 5'd14;
  localparam logic [OP_W-1:0] OP_DIVU   = 5'd15;
  localparam logic [OP_W-1:0] OP_REM    = 5'd16;
  localparam logic [OP_W-1:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return (op >= OP_MUL) && (op <= OP_MULHU);
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

  // Operand a is treated as two's complement for these ops
  function automatic logic op_a_signed(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative shift-add multiplier / restoring divider on magnitudes with final sign fix-up.
// done/result are valid combinationally in the last iteration cycle.
module muldiv_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned PW = 2 * WIDTH;

  logic            busy;
  logic [CW-1:0]   cnt;
  logic [OP_W-1:0] op_q;
  logic [WIDTH-1:0] acc, lo, opnd;
  logic            neg_p, neg_r;

  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, r_sh, diff;
  logic [PW-1:0]    prod, prod_s;
  logic [WIDTH-1:0] quo, rmd, quo_s, rmd_s;
  logic             ge;

  // Operand magnitudes and signs at start
  always_comb begin
    a_sgn = op_a_signed(op) && a[WIDTH-1];
    b_sgn = op_b_signed(op) && b[WIDTH-1];
    a_mag = a_sgn ? (~a + WIDTH'(1)) : a;
    b_mag = b_sgn ? (~b + WIDTH'(1)) : b;
  end

  // One iteration step for both datapaths; acc/lo are shared between them
  always_comb begin
    sum    = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    prod   = {sum, lo[WIDTH-1:1]};
    r_sh   = {acc, lo[WIDTH-1]};
    diff   = r_sh - {1'b0, opnd};
    ge     = ~diff[WIDTH];
    quo    = {lo[WIDTH-2:0], ge};
    rmd    = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    prod_s = neg_p ? (~prod + PW'(1)) : prod;
    quo_s  = neg_p ? (~quo + WIDTH'(1)) : quo;
    rmd_s  = neg_r ? (~rmd + WIDTH'(1)) : rmd;
    case (op_q)
      OP_MUL:                        result = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_s[PW-1:WIDTH];
      OP_DIV, OP_DIVU:               result = quo_s;
      default:                       result = rmd_s;
    endcase
    done = busy && (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= '0;
      acc   <= '0;
      lo    <= '0;
      opnd  <= '0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      op_q  <= op;
      acc   <= '0;
      lo    <= is_mul_op(op) ? b_mag : a_mag;
      opnd  <= is_mul_op(op) ? a_mag : b_mag;
      neg_p <= a_sgn ^ b_sgn;
      neg_r <= a_sgn;
    end else if (busy) begin
      acc <= is_mul_op(op_q) ? prod[PW-1:WIDTH] : rmd;
      lo  <= is_mul_op(op_q) ? prod[WIDTH-1:0]  : quo;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle integer ops plus iterative mul/div, valid/ready on both sides.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] quick_c, load_val_c, core_result;
  logic             div_zero_c, div_ovf_c, special_c;
  logic             accept_c, start_c, load_c, core_done;

  assign sh = b[SHW-1:0];

  // Single-cycle results, including the divide shortcuts that skip iteration
  always_comb begin
    div_zero_c = (b == '0);
    div_ovf_c  = ((alu_ctrl == OP_DIV) || (alu_ctrl == OP_REM)) &&
                 (a == MIN_VAL) && (b == '1);
    special_c  = is_div_op(alu_ctrl) && (div_zero_c || div_ovf_c);
    quick_c    = '0;
    case (alu_ctrl)
      OP_ADD:           quick_c = a + b;
      OP_SUB:           quick_c = a - b;
      OP_AND:           quick_c = a & b;
      OP_OR:            quick_c = a | b;
      OP_XOR:           quick_c = a ^ b;
      OP_SLL:           quick_c = a << sh;
      OP_SRL:           quick_c = a >> sh;
      OP_SRA:           quick_c = $signed(a) >>> sh;
      OP_SLT:           quick_c = WIDTH'($signed(a) < $signed(b));
      OP_SLTU:          quick_c = WIDTH'(a < b);
      OP_DIV, OP_DIVU:  quick_c = div_zero_c ? '1 : MIN_VAL;
      OP_REM, OP_REMU:  quick_c = div_zero_c ? a : '0;
      default:          quick_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_mul_op(alu_ctrl))                     state_nxt = ST_MUL;
          else if (is_div_op(alu_ctrl) && !special_c)  state_nxt = ST_DIV;
          else                                         state_nxt = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: if (core_done) state_nxt = ST_DONE;
      ST_DONE:        if (out_ready) state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    accept_c   = (state == ST_IDLE) && in_valid;
    start_c    = accept_c && ((state_nxt == ST_MUL) || (state_nxt == ST_DIV));
    load_c     = (accept_c && (state_nxt == ST_DONE)) ||
                 (((state == ST_MUL) || (state == ST_DIV)) && core_done);
    load_val_c = accept_c ? quick_c : core_result;
  end

  // Result and handshake registers; alu_out holds between operations
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      alu_out   <= '0;
      zero      <= 1'b1;
    end else begin
      in_ready  <= (state_nxt == ST_IDLE);
      out_valid <= (state_nxt == ST_DONE);
      if (load_c) begin
        alu_out <= load_val_c;
        zero    <= (load_val_c == '0);
      end
    end
  end

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (start_c),
    .op     (alu_ctrl),
    .a      (a),
    .b      (b),
    .done   (core_done),
    .result (core_result)
  );

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed table, random ops against a reference model, corner sequences.
module tb_seq_alu;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready, zero;
  logic [W-1:0]  a, b, alu_out;
  logic [4:0]    alu_ctrl;

  int total = 0;
  int passed = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_ctrl  (alu_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model written straight from the arithmetic definitions
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    longint sp;
    logic [63:0] up, uy64;
    sx = x;
    sy = y;
    uy64 = {32'b0, y};
    case (op)
      5'd0:  return x + y;
      5'd1:  return x - y;
      5'd2:  return x & y;
      5'd3:  return x | y;
      5'd4:  return x << y[4:0];
      5'd5:  return (sx < sy) ? 32'd1 : 32'd0;
      5'd6:  return x ^ y;
      5'd7:  return x >> y[4:0];
      5'd8:  return 32'(sx >>> y[4:0]);
      5'd9:  return (x < y) ? 32'd1 : 32'd0;
      5'd10: begin sp = longint'(sx) * longint'(sy); return sp[31:0]; end
      5'd11: begin sp = longint'(sx) * longint'(sy); return sp[63:32]; end
      5'd12: begin sp = longint'(sx) * longint'(uy64); return sp[63:32]; end
      5'd13: begin up = {32'b0, x} * uy64; return up[63:32]; end
      5'd14: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sx / sy);
      end
      5'd15: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'd16: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sx % sy);
      end
      5'd17: return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    if (op >= 10 && op <= 13) return W + 1;
    if (op >= 14 && op <= 17) begin
      if (y == 0) return 1;
      if ((op == 14 || op == 16) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      return W + 1;
    end
    return 1;
  endfunction

  // Issue one op, measure cycles from accept to out_valid, check result, then drain it
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int lat_exp);
    int lat;
    @(negedge clk);
    check({name, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    alu_ctrl = op;
    a = x;
    b = y;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'(lat_exp));
    check({name, "_out"}, alu_out, exp);
    check({name, "_zero"}, 32'(zero), 32'(exp == 0));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    logic        seen;

    vecs[0]  = '{5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1};
    vecs[1]  = '{5'd1,  32'd5,         32'd7,         32'hFFFF_FFFE, 1};
    vecs[2]  = '{5'd1,  32'd5,         32'd5,         32'd0,         1};
    vecs[3]  = '{5'd4,  32'd1,         32'h21,        32'd2,         1};
    vecs[4]  = '{5'd5,  32'hFFFF_FFFF, 32'd1,         32'd1,         1};
    vecs[5]  = '{5'd9,  32'hFFFF_FFFF, 32'd1,         32'd0,         1};
    vecs[6]  = '{5'd7,  32'h8000_0000, 32'd4,         32'h0800_0000, 1};
    vecs[7]  = '{5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[8]  = '{5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[9]  = '{5'd10, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 33};
    vecs[10] = '{5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[11] = '{5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[12] = '{5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[13] = '{5'd15, 32'd100,       32'd0,         32'hFFFF_FFFF, 1};
    vecs[14] = '{5'd17, 32'd100,       32'd0,         32'd100,       1};
    vecs[15] = '{5'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vecs[16] = '{5'd16, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[17] = '{5'd20, 32'd5,         32'd3,         32'd0,         1};
    vecs[18] = '{5'd15, 32'd100,       32'd7,         32'd14,        33};

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    alu_ctrl = '0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu_out", alu_out, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < 19; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Result held under back-pressure; requests during DONE are ignored
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = 5'd8;
    a = 32'h8000_0000;
    b = 32'h24;
    @(negedge clk);
    alu_ctrl = 5'd0;
    a = 32'd1;
    b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_out", i), alu_out, 32'hF800_0000);
      check($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d_ready", i), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_after_valid", 32'(out_valid), 32'd0);
    check("stall_after_ready", 32'(in_ready), 32'd1);
    check("stall_hold_out", alu_out, 32'hF800_0000);

    // Reset in the middle of a multiply aborts it
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = 5'd10;
    a = 32'd123;
    b = 32'd456;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("abort_out", alu_out, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_never_valid", 32'(seen), 32'd0);

    // Random ops against the reference model
    for (int i = 0; i < 80; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      ra = rand_operand();
      rb = rand_operand();
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, ref_alu(rop, ra, rb), ref_lat(rop, ra, rb));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
